operand_sequencer: RTL and testbench

Upstream feeder and result collector for the datapath/controller pair. Accepts operand pairs plus a destination register address on a valid/ready input stream and buffers them in a DEPTH-entry FIFO. Issues one operation at a time to the datapath by driving operands, write/read addresses and start, then waits for done. Captures the register-file read value and presents it on a valid/ready output stream.

---
 rtl/operand_sequencer.sv | 171 +++++++++++++++++
 tb/tb_operand_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_sequencer.sv
// Operand sequencer: buffers operand pairs in a small FIFO, issues them one at a time to the
// datapath, waits for done, and presents the captured register-file value on an output stream.
module operand_sequencer #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                      sq_clk,
  input  logic                      sq_reset,
  input  logic                      sq_in_valid,
  output logic                      sq_in_ready,
  input  logic [WIDTH-1:0]          sq_in_a,
  input  logic [WIDTH-1:0]          sq_in_b,
  input  logic [ADDR_W-1:0]         sq_in_addr,
  output logic                      sq_start,
  output logic [WIDTH-1:0]          sq_inp1,
  output logic [WIDTH-1:0]          sq_inp2,
  output logic [ADDR_W-1:0]         sq_WriteAddress,
  output logic [ADDR_W-1:0]         sq_ReadAddress,
  input  logic                      sq_done,
  input  logic [WIDTH-1:0]          sq_read,
  output logic                      sq_out_valid,
  input  logic                      sq_out_ready,
  output logic [WIDTH-1:0]          sq_out_result,
  output logic [ADDR_W-1:0]         sq_out_addr,
  output logic                      sq_timeout,
  output logic [$clog2(DEPTH):0]    sq_count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned TmrW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StHold} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0]  mem_a_q    [DEPTH];
  logic [WIDTH-1:0]  mem_b_q    [DEPTH];
  logic [ADDR_W-1:0] mem_addr_q [DEPTH];

  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [TmrW-1:0]   timer_q, timer_d;
  logic              done_q;
  logic              timeout_q, timeout_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [ADDR_W-1:0] op_addr_q, op_addr_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [ADDR_W-1:0] res_addr_q, res_addr_d;

  logic push, pop, done_rise, timer_expired;

  assign sq_in_ready   = (count_q != CntW'(DEPTH));
  assign push          = sq_in_valid && sq_in_ready;
  assign pop           = (state_q == StIdle) && (count_q != '0);
  assign done_rise     = sq_done && !done_q;
  assign timer_expired = (timer_q == TmrW'(TIMEOUT - 1));

  // FIFO storage carries no reset; occupancy alone defines validity.
  always_ff @(posedge sq_clk) begin
    if (push) begin
      mem_a_q[wr_ptr_q]    <= sq_in_a;
      mem_b_q[wr_ptr_q]    <= sq_in_b;
      mem_addr_q[wr_ptr_q] <= sq_in_addr;
    end
  end

  always_ff @(posedge sq_clk or negedge sq_reset) begin
    if (!sq_reset) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_addr_q  <= '0;
      res_q      <= '0;
      res_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      done_q     <= sq_done;
      timeout_q  <= timeout_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_addr_q  <= op_addr_d;
      res_q      <= res_d;
      res_addr_q <= res_addr_d;
    end
  end

  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (count_q != '0) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait: begin
        if (done_rise) begin
          state_d = StHold;
        end else if (timer_expired) begin
          state_d = StIdle;
        end
      end
      StHold:  if (sq_out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_addr_d  = op_addr_q;
    res_d      = res_q;
    res_addr_d = res_addr_q;
    timer_d    = timer_q;
    timeout_d  = timeout_q;
    if (pop) begin
      op_a_d    = mem_a_q[rd_ptr_q];
      op_b_d    = mem_b_q[rd_ptr_q];
      op_addr_d = mem_addr_q[rd_ptr_q];
    end
    if (state_q == StIssue) begin
      timer_d = '0;
    end
    if (state_q == StWait) begin
      timer_d = timer_q + TmrW'(1);
      if (done_rise) begin
        res_d      = sq_read;
        res_addr_d = op_addr_q;
      end else if (timer_expired) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_comb begin
    sq_start     = (state_q == StIssue) || (state_q == StWait);
    sq_out_valid = (state_q == StHold);
  end

  assign sq_inp1         = op_a_q;
  assign sq_inp2         = op_b_q;
  assign sq_WriteAddress = op_addr_q;
  assign sq_ReadAddress  = op_addr_q;
  assign sq_out_result   = res_q;
  assign sq_out_addr     = res_addr_q;
  assign sq_timeout      = timeout_q;
  assign sq_count        = count_q;

endmodule

// File: tb/tb_operand_sequencer.sv
// Bench for operand_sequencer: directed steps plus random traffic against a queue-based model
// of the FIFO and a simple datapath responder.
module tb_operand_sequencer;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned ADDR_W  = 5;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 8;

  typedef struct {
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [ADDR_W-1:0] addr;
  } op_t;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              sq_in_ready;
  logic [WIDTH-1:0]  in_a, in_b;
  logic [ADDR_W-1:0] in_addr;
  logic              sq_start;
  logic [WIDTH-1:0]  sq_inp1, sq_inp2;
  logic [ADDR_W-1:0] sq_waddr, sq_raddr;
  logic              sq_done;
  logic [WIDTH-1:0]  sq_read;
  logic              sq_out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  sq_out_result;
  logic [ADDR_W-1:0] sq_out_addr;
  logic              sq_timeout;
  logic [$clog2(DEPTH):0] sq_count;

  operand_sequencer #(
    .WIDTH  (WIDTH),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .sq_clk         (clk),
    .sq_reset       (rst_n),
    .sq_in_valid    (in_valid),
    .sq_in_ready    (sq_in_ready),
    .sq_in_a        (in_a),
    .sq_in_b        (in_b),
    .sq_in_addr     (in_addr),
    .sq_start       (sq_start),
    .sq_inp1        (sq_inp1),
    .sq_inp2        (sq_inp2),
    .sq_WriteAddress(sq_waddr),
    .sq_ReadAddress (sq_raddr),
    .sq_done        (sq_done),
    .sq_read        (sq_read),
    .sq_out_valid   (sq_out_valid),
    .sq_out_ready   (out_ready),
    .sq_out_result  (sq_out_result),
    .sq_out_addr    (sq_out_addr),
    .sq_timeout     (sq_timeout),
    .sq_count       (sq_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  op_t        pend[$];
  op_t        cur;
  logic [WIDTH-1:0] exp_res;
  bit         prev_start;
  bit         auto_dp;
  bit         rand_lat;
  int         dp_lat;
  int         dp_cnt;
  int         n_push, n_out, n_drop;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: model the FIFO and datapath, then compare outputs #1 after the edge.
  task automatic step();
    bit  rdy_exp, pushing, hs;
    op_t t;
    rdy_exp = (pend.size() < DEPTH);
    pushing = in_valid && rdy_exp;
    hs      = sq_out_valid && out_ready;
    t.a = in_a; t.b = in_b; t.addr = in_addr;
    @(posedge clk);
    #1;
    if (pushing) begin
      pend.push_back(t);
      n_push++;
    end
    if (hs) begin
      n_out++;
      check("valid_drops_after_hs", sq_out_valid, 0);
    end
    if (sq_start && !prev_start) begin
      check("pop_nonempty", pend.size() != 0, 1);
      if (pend.size() != 0) cur = pend.pop_front();
      exp_res = cur.a + cur.b;
      if (rand_lat) dp_lat = $urandom_range(1, 6);
    end
    prev_start = sq_start;
    dp_cnt = sq_start ? dp_cnt + 1 : 0;
    if (auto_dp) begin
      sq_done = sq_start && (dp_cnt > dp_lat);
      sq_read = cur.a + cur.b;
    end
    check("count", sq_count, pend.size());
    check("in_ready", sq_in_ready, pend.size() < DEPTH);
    check("start_vs_valid", sq_start && sq_out_valid, 0);
    if (sq_start || sq_out_valid) begin
      check("inp1", sq_inp1, cur.a);
      check("inp2", sq_inp2, cur.b);
      check("waddr", sq_waddr, cur.addr);
      check("raddr", sq_raddr, cur.addr);
    end
    if (sq_out_valid) begin
      check("out_result", sq_out_result, exp_res);
      check("out_addr", sq_out_addr, cur.addr);
    end
  endtask

  task automatic push(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [ADDR_W-1:0] addr);
    in_valid = 1'b1; in_a = a; in_b = b; in_addr = addr;
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain(input int bound);
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < bound && (n_out != n_push - n_drop); i++) step();
    check("drain_complete", n_out, n_push - n_drop);
    check("drain_fifo_empty", pend.size(), 0);
  endtask

  initial begin
    int cnt;
    bit seen;
    logic [WIDTH-1:0] r2;
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_addr = '0;
    out_ready = 1'b0; sq_done = 1'b0; sq_read = '0;
    auto_dp = 1'b0; rand_lat = 1'b0; dp_lat = 1; dp_cnt = 0; prev_start = 1'b0;
    n_push = 0; n_out = 0; n_drop = 0; exp_res = '0;
    cur.a = '0; cur.b = '0; cur.addr = '0;

    #2;
    check("rst_in_ready", sq_in_ready, 1);
    check("rst_start", sq_start, 0);
    check("rst_count", sq_count, 0);
    check("rst_out_valid", sq_out_valid, 0);
    check("rst_timeout", sq_timeout, 0);
    check("rst_result", sq_out_result, 0);
    #10 rst_n = 1'b1;

    // Single op with a 6-cycle datapath.
    auto_dp = 1'b1; dp_lat = 6; out_ready = 1'b1;
    push(32'd5, 32'd7, 5'd1);
    check("single_count", sq_count, 1);
    check("single_no_start_yet", sq_start, 0);
    step();
    check("single_start", sq_start, 1);
    cnt = 1; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      step();
      if (sq_out_valid) seen = 1'b1;
      else if (sq_start) cnt++;
    end
    check("single_seen", seen, 1);
    check("single_start_cycles", cnt, 7);
    check("single_result", sq_out_result, 32'd12);
    check("single_addr", sq_out_addr, 5'd1);
    check("single_inp1", sq_inp1, 32'd5);
    check("single_inp2", sq_inp2, 32'd7);
    step();

    // Fill the FIFO while the in-flight op waits; the sixth push must be refused.
    auto_dp = 1'b0; sq_done = 1'b0;
    for (int i = 0; i < 5; i++) push($urandom, $urandom, 5'($urandom));
    check("fill_count", sq_count, 4);
    check("fill_ready_low", sq_in_ready, 0);
    in_valid = 1'b1; in_a = 32'hdead_beef; in_b = 32'h1; in_addr = 5'd31;
    step();
    in_valid = 1'b0;
    check("fill_count_held", sq_count, 4);
    auto_dp = 1'b1; dp_lat = 1;
    drain(200);

    // Output backpressure for 10 cycles with another op queued.
    dp_lat = 3; out_ready = 1'b0;
    push($urandom, $urandom, 5'($urandom));
    push($urandom, $urandom, 5'($urandom));
    seen = 1'b0;
    for (int i = 0; i < 30 && !seen; i++) begin
      step();
      seen = sq_out_valid;
    end
    check("bp_seen", seen, 1);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid_held", sq_out_valid, 1);
      check("bp_no_start", sq_start, 0);
      step();
    end
    drain(100);

    // Stale done: high before WAIT, only the next rising edge counts.
    auto_dp = 1'b0; sq_done = 1'b1; sq_read = 32'h1111_1111;
    push($urandom, $urandom, 5'($urandom));
    seen = sq_start;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = sq_start;
    end
    check("stale_started", seen, 1);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stale_no_capture", sq_out_valid, 0);
    end
    sq_done = 1'b0; sq_read = 32'h2222_2222;
    step();
    check("stale_still_waiting", sq_out_valid, 0);
    r2 = $urandom;
    sq_done = 1'b1; sq_read = r2; exp_res = r2;
    step();
    check("stale_capture", sq_out_valid, 1);
    check("stale_result", sq_out_result, r2);
    sq_done = 1'b0;
    drain(20);
    check("pre_timeout_flag", sq_timeout, 0);

    // Timeout: first op never gets done, second op completes normally.
    push($urandom, $urandom, 5'($urandom));
    push($urandom, $urandom, 5'($urandom));
    seen = sq_start;
    for (int i = 0; i < 10 && !seen; i++) begin
      step();
      seen = sq_start;
    end
    check("to_started", seen, 1);
    cnt = 1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!sq_start) break;
      cnt++;
      check("to_no_valid", sq_out_valid, 0);
    end
    check("to_start_cycles", cnt, 1 + TIMEOUT);
    check("to_no_valid_after", sq_out_valid, 0);
    check("to_flag", sq_timeout, 1);
    n_drop++;
    auto_dp = 1'b1; dp_lat = 2;
    drain(100);
    check("to_flag_sticky", sq_timeout, 1);

    // Random traffic.
    rand_lat = 1'b1;
    for (int i = 0; i < 120; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_a      = $urandom;
      in_b      = $urandom;
      in_addr   = 5'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      step();
    end
    drain(600);
    rand_lat = 1'b0;

    // Asynchronous reset in the middle of WAIT with an op still queued.
    auto_dp = 1'b0; sq_done = 1'b0;
    push($urandom, $urandom, 5'($urandom));
    push($urandom, $urandom, 5'($urandom));
    step();
    check("rw_in_wait", sq_start, 1);
    check("rw_queued", sq_count, 1);
    #3 rst_n = 1'b0;
    #1;
    check("rw_start_low", sq_start, 0);
    check("rw_count_zero", sq_count, 0);
    check("rw_valid_low", sq_out_valid, 0);
    check("rw_in_ready", sq_in_ready, 1);
    check("rw_timeout_cleared", sq_timeout, 0);
    pend.delete();
    n_push = 0; n_out = 0; n_drop = 0; prev_start = 1'b0; dp_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("rw_idle_no_start", sq_start, 0);
    auto_dp = 1'b1; dp_lat = 2;
    push(32'd100, 32'd23, 5'd9);
    drain(40);
    check("rw_post_result", sq_out_result, 32'd123);
    check("rw_post_addr", sq_out_addr, 5'd9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1, "watchdog");
  end

endmodule
